// File: rtl/ifetch_controller_pkg.sv
// Shared types and constants for the instruction fetch controller.
// The FSM state encoding is exported so benches can observe the controller state.
package ifetch_controller_pkg;

  typedef enum logic {
    ST_FETCH  = 1'b0,
    ST_HALTED = 1'b1
  } state_t;

  localparam logic [31:0] PC_STEP = 32'd4;
  localparam int          WAIT_W  = 3;

endpackage

// File: rtl/ifetch_controller_fetch_wait_counter.sv
// Wait-state down-counter: reloads on demand, counts down to zero and holds there.
// o_zero tells the fetch logic that the memory address has been held long enough.
module fetch_wait_counter
  import ifetch_controller_pkg::*;
#(
  parameter logic [WAIT_W-1:0] RELOAD = '0
) (
  input  logic clk,
  input  logic reset,
  input  logic i_reload,
  input  logic i_dec,
  output logic o_zero
);

  logic [WAIT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= RELOAD;
    end else if (i_reload) begin
      r_cnt <= RELOAD;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/ifetch_controller.sv
// Fetch sequencer for the MIPS core: owns the fetch PC, models memory wait states,
// and hands each fetched word to decode through a one-entry valid/ready buffer.
//
// Handshake: a word moves to decode on any rising edge where instr_valid && instr_ready;
// while instr_valid is high and instr_ready is low, instr_out/pc_out do not change.
module ifetch_controller
  import ifetch_controller_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        halt_req,
  output logic        halted,
  output logic        align_err,
  output logic [31:0] fetch_count,
  output state_t      dbg_state
);

  localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_STATES[WAIT_W-1:0];

  state_t      r_state;
  logic [31:0] r_fetch_pc;
  logic [31:0] r_instr;
  logic [31:0] r_pc_out;
  logic        r_valid;
  logic        r_halted;
  logic        r_align_err;
  logic [31:0] r_fetch_count;

  logic w_in_fetch;
  logic w_wait_zero;
  logic w_xfer;
  logic w_redirect;
  logic w_load;

  assign w_in_fetch = (r_state == ST_FETCH);
  assign w_xfer     = r_valid && instr_ready;
  // halt_req outranks a same-cycle branch, so it also suppresses the redirect.
  assign w_redirect = w_in_fetch && branch_taken && !halt_req;
  assign w_load     = w_in_fetch && w_wait_zero && (!r_valid || instr_ready)
                      && !branch_taken && !halt_req;

  fetch_wait_counter #(
    .RELOAD (WAIT_INIT)
  ) u_wait (
    .clk      (clk),
    .reset    (reset),
    .i_reload (w_load || w_redirect),
    .i_dec    (w_in_fetch),
    .o_zero   (w_wait_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_FETCH;
      r_fetch_pc    <= RESET_PC;
      r_instr       <= '0;
      r_pc_out      <= '0;
      r_valid       <= 1'b0;
      r_halted      <= 1'b0;
      r_align_err   <= 1'b0;
      r_fetch_count <= '0;
    end else begin
      r_align_err <= w_redirect && (|branch_target[1:0]);
      if (w_xfer) begin
        r_fetch_count <= r_fetch_count + 32'd1;
      end

      case (r_state)
        ST_FETCH: begin
          if (halt_req) begin
            r_state  <= ST_HALTED;
            r_halted <= 1'b1;
          end
          if (w_redirect) begin
            r_fetch_pc <= {branch_target[31:2], 2'b00};
            r_valid    <= 1'b0;
          end else if (w_load) begin
            r_instr    <= imem_instr;
            r_pc_out   <= r_fetch_pc;
            r_valid    <= 1'b1;
            r_fetch_pc <= r_fetch_pc + PC_STEP;
          end else if (w_xfer) begin
            r_valid <= 1'b0;
          end
        end
        ST_HALTED: begin
          // Drain the pending word, if any; nothing new is fetched.
          if (w_xfer) begin
            r_valid <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_FETCH;
        end
      endcase
    end
  end

  assign imem_addr   = r_fetch_pc;
  assign instr_out   = r_instr;
  assign pc_out      = r_pc_out;
  assign instr_valid = r_valid;
  assign halted      = r_halted;
  assign align_err   = r_align_err;
  assign fetch_count = r_fetch_count;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_ifetch_controller.sv
// Bench for ifetch_controller: three parameterisations, directed timing checks and a
// scoreboard of expected {pc, instr} deliveries popped on every observed handshake.
module tb_ifetch_controller;
  import ifetch_controller_pkg::*;

  localparam int NDUT = 3;

  logic        clk;
  logic        rst   [NDUT];
  logic        rdy   [NDUT];
  logic        br    [NDUT];
  logic [31:0] tgt   [NDUT];
  logic        hlt   [NDUT];
  logic [31:0] w_addr  [NDUT];
  logic [31:0] w_imem  [NDUT];
  logic [31:0] w_instr [NDUT];
  logic [31:0] w_pc    [NDUT];
  logic        w_valid [NDUT];
  logic        w_halted[NDUT];
  logic        w_align [NDUT];
  logic [31:0] w_count [NDUT];
  state_t      w_state [NDUT];

  logic [63:0] exp_q[$];
  int          act;
  int          n_checks;
  int          n_fail;

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    if (addr == 32'h0000_0000)      return 32'h0004_A000;
    else if (addr == 32'h0000_0004) return 32'h10E4_FFFC;
    else                            return {addr[15:0], ~addr[15:0]};
  endfunction

  function automatic logic [31:0] reset_pc_of(input int d);
    return (d == 2) ? 32'hFFFF_FFFC : 32'h0000_0000;
  endfunction

  assign w_imem[0] = mem_word(w_addr[0]);
  assign w_imem[1] = mem_word(w_addr[1]);
  assign w_imem[2] = mem_word(w_addr[2]);

  ifetch_controller #(.RESET_PC(32'h0000_0000), .WAIT_STATES(0)) u_dut0 (
    .clk(clk), .reset(rst[0]), .imem_addr(w_addr[0]), .imem_instr(w_imem[0]),
    .instr_out(w_instr[0]), .pc_out(w_pc[0]), .instr_valid(w_valid[0]),
    .instr_ready(rdy[0]), .branch_taken(br[0]), .branch_target(tgt[0]),
    .halt_req(hlt[0]), .halted(w_halted[0]), .align_err(w_align[0]),
    .fetch_count(w_count[0]), .dbg_state(w_state[0]));

  ifetch_controller #(.RESET_PC(32'h0000_0000), .WAIT_STATES(2)) u_dut1 (
    .clk(clk), .reset(rst[1]), .imem_addr(w_addr[1]), .imem_instr(w_imem[1]),
    .instr_out(w_instr[1]), .pc_out(w_pc[1]), .instr_valid(w_valid[1]),
    .instr_ready(rdy[1]), .branch_taken(br[1]), .branch_target(tgt[1]),
    .halt_req(hlt[1]), .halted(w_halted[1]), .align_err(w_align[1]),
    .fetch_count(w_count[1]), .dbg_state(w_state[1]));

  ifetch_controller #(.RESET_PC(32'hFFFF_FFFC), .WAIT_STATES(3)) u_dut2 (
    .clk(clk), .reset(rst[2]), .imem_addr(w_addr[2]), .imem_instr(w_imem[2]),
    .instr_out(w_instr[2]), .pc_out(w_pc[2]), .instr_valid(w_valid[2]),
    .instr_ready(rdy[2]), .branch_taken(br[2]), .branch_target(tgt[2]),
    .halt_req(hlt[2]), .halted(w_halted[2]), .align_err(w_align[2]),
    .fetch_count(w_count[2]), .dbg_state(w_state[2]));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_seq(input logic [31:0] start, input int n);
    logic [31:0] pc;
    pc = start;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({pc, mem_word(pc)});
      pc = pc + 32'd4;
    end
  endtask

  task automatic check_reset(input int d);
    check_eq("rst_valid",  {31'd0, w_valid[d]},  32'd0);
    check_eq("rst_instr",  w_instr[d],           32'd0);
    check_eq("rst_pc_out", w_pc[d],              32'd0);
    check_eq("rst_addr",   w_addr[d],            reset_pc_of(d));
    check_eq("rst_halted", {31'd0, w_halted[d]}, 32'd0);
    check_eq("rst_align",  {31'd0, w_align[d]},  32'd0);
    check_eq("rst_count",  w_count[d],           32'd0);
    check_eq("rst_state",  {31'd0, w_state[d]},  {31'd0, ST_FETCH});
  endtask

  // scoreboard: every handshake the next edge will take must match the queue head
  always @(negedge clk) begin
    logic [63:0] e;
    if (!rst[act] && w_valid[act] && rdy[act]) begin
      if (exp_q.size() == 0) begin
        check_eq("sb_underflow", w_pc[act], 32'hDEAD_BEEF);
      end else begin
        e = exp_q.pop_front();
        check_eq("sb_pc",    w_pc[act],    e[63:32]);
        check_eq("sb_instr", w_instr[act], e[31:0]);
      end
    end
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    act      = 0;
    for (int i = 0; i < NDUT; i++) begin
      rst[i] = 1'b1; rdy[i] = 1'b0; br[i] = 1'b0; tgt[i] = '0; hlt[i] = 1'b0;
    end

    // ---- DUT0: WAIT_STATES=0, streaming, redirects, backpressure
    act = 0; rdy[0] = 1'b1;
    tick(); tick();
    check_reset(0);
    exp_q.delete(); push_seq(32'h0, 8);
    rst[0] = 1'b0;
    tick();
    check_eq("a0_addr", w_addr[0], 32'h4);
    check_eq("a0_valid", {31'd0, w_valid[0]}, 32'd1);
    check_eq("a0_pc", w_pc[0], 32'h0);
    check_eq("a0_instr", w_instr[0], 32'h0004_A000);
    check_eq("a0_count", w_count[0], 32'd0);
    tick();
    check_eq("a1_addr", w_addr[0], 32'h8);
    check_eq("a1_pc", w_pc[0], 32'h4);
    check_eq("a1_instr", w_instr[0], 32'h10E4_FFFC);
    check_eq("a1_count", w_count[0], 32'd1);
    tick();
    check_eq("a2_addr", w_addr[0], 32'hC);
    check_eq("a2_count", w_count[0], 32'd2);
    br[0] = 1'b1; tgt[0] = 32'h0000_0042;
    tick();
    check_eq("br_valid", {31'd0, w_valid[0]}, 32'd0);
    check_eq("br_addr", w_addr[0], 32'h40);
    check_eq("br_align", {31'd0, w_align[0]}, 32'd1);
    check_eq("br_count", w_count[0], 32'd3);
    br[0] = 1'b0; exp_q.delete(); push_seq(32'h40, 4);
    tick();
    check_eq("br1_align", {31'd0, w_align[0]}, 32'd0);
    check_eq("br1_valid", {31'd0, w_valid[0]}, 32'd1);
    check_eq("br1_pc", w_pc[0], 32'h40);
    check_eq("br1_count", w_count[0], 32'd3);
    tick();
    check_eq("br2_pc", w_pc[0], 32'h44);
    check_eq("br2_count", w_count[0], 32'd4);
    br[0] = 1'b1; tgt[0] = 32'h0000_0100;
    tick();
    check_eq("bra_addr", w_addr[0], 32'h100);
    check_eq("bra_align", {31'd0, w_align[0]}, 32'd0);
    check_eq("bra_count", w_count[0], 32'd5);
    br[0] = 1'b0; exp_q.delete(); push_seq(32'h100, 4);
    tick();
    check_eq("bra1_pc", w_pc[0], 32'h100);

    rst[0] = 1'b1;
    tick();
    check_reset(0);
    exp_q.delete(); push_seq(32'h0, 4);
    rdy[0] = 1'b0; rst[0] = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("bp_instr", w_instr[0], 32'h0004_A000);
      check_eq("bp_pc", w_pc[0], 32'h0);
      check_eq("bp_addr", w_addr[0], 32'h4);
      check_eq("bp_count", w_count[0], 32'd0);
      check_eq("bp_valid", {31'd0, w_valid[0]}, 32'd1);
    end
    rdy[0] = 1'b1;
    tick();
    check_eq("bp_resume_pc", w_pc[0], 32'h4);
    check_eq("bp_resume_count", w_count[0], 32'd1);
    tick();
    check_eq("bp_resume2_pc", w_pc[0], 32'h8);
    check_eq("bp_resume2_count", w_count[0], 32'd2);
    rst[0] = 1'b1;
    tick();

    // ---- DUT1: WAIT_STATES=2 latency and throughput
    act = 1; rdy[1] = 1'b1;
    tick();
    check_reset(1);
    exp_q.delete(); push_seq(32'h0, 4);
    rst[1] = 1'b0;
    tick();
    check_eq("w2_t1_valid", {31'd0, w_valid[1]}, 32'd0);
    check_eq("w2_t1_addr", w_addr[1], 32'h0);
    tick();
    check_eq("w2_t2_valid", {31'd0, w_valid[1]}, 32'd0);
    tick();
    check_eq("w2_t3_valid", {31'd0, w_valid[1]}, 32'd1);
    check_eq("w2_t3_pc", w_pc[1], 32'h0);
    check_eq("w2_t3_addr", w_addr[1], 32'h4);
    tick();
    check_eq("w2_t4_valid", {31'd0, w_valid[1]}, 32'd0);
    check_eq("w2_t4_count", w_count[1], 32'd1);
    check_eq("w2_t4_addr", w_addr[1], 32'h4);
    tick();
    check_eq("w2_t5_valid", {31'd0, w_valid[1]}, 32'd0);
    check_eq("w2_t5_addr", w_addr[1], 32'h4);
    tick();
    check_eq("w2_t6_valid", {31'd0, w_valid[1]}, 32'd1);
    check_eq("w2_t6_pc", w_pc[1], 32'h4);
    check_eq("w2_t6_instr", w_instr[1], 32'h10E4_FFFC);
    check_eq("w2_t6_addr", w_addr[1], 32'h8);
    rst[1] = 1'b1;
    tick();

    // ---- DUT2: WAIT_STATES=3, RESET_PC at top of memory: wrap, mid-wait reset, halt
    act = 2; rdy[2] = 1'b0;
    tick();
    check_reset(2);
    exp_q.delete(); push_seq(32'hFFFF_FFFC, 3);
    rst[2] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("w3_wait_valid", {31'd0, w_valid[2]}, 32'd0);
    end
    tick();
    check_eq("wrap_valid", {31'd0, w_valid[2]}, 32'd1);
    check_eq("wrap_pc", w_pc[2], 32'hFFFF_FFFC);
    check_eq("wrap_addr", w_addr[2], 32'h0);
    tick(); tick();
    check_eq("mid_valid", {31'd0, w_valid[2]}, 32'd1);
    rst[2] = 1'b1;
    tick();
    check_reset(2);

    exp_q.delete(); push_seq(32'hFFFF_FFFC, 3);
    rst[2] = 1'b0;
    tick(); tick(); tick(); tick();
    check_eq("h_pre_pc", w_pc[2], 32'hFFFF_FFFC);
    hlt[2] = 1'b1; br[2] = 1'b1; tgt[2] = 32'h0000_0042;
    tick();
    check_eq("h_halted", {31'd0, w_halted[2]}, 32'd1);
    check_eq("h_state", {31'd0, w_state[2]}, {31'd0, ST_HALTED});
    check_eq("h_align", {31'd0, w_align[2]}, 32'd0);
    check_eq("h_addr", w_addr[2], 32'h0);
    check_eq("h_valid", {31'd0, w_valid[2]}, 32'd1);
    hlt[2] = 1'b0; tgt[2] = 32'h0000_0080;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("hh_addr", w_addr[2], 32'h0);
      check_eq("hh_valid", {31'd0, w_valid[2]}, 32'd1);
      check_eq("hh_align", {31'd0, w_align[2]}, 32'd0);
      check_eq("hh_pc", w_pc[2], 32'hFFFF_FFFC);
    end
    br[2] = 1'b0; rdy[2] = 1'b1;
    tick();
    check_eq("hd_valid", {31'd0, w_valid[2]}, 32'd0);
    check_eq("hd_count", w_count[2], 32'd1);
    check_eq("hd_halted", {31'd0, w_halted[2]}, 32'd1);
    tick(); tick();
    check_eq("hd2_valid", {31'd0, w_valid[2]}, 32'd0);
    check_eq("hd2_addr", w_addr[2], 32'h0);
    check_eq("hd2_count", w_count[2], 32'd1);
    rst[2] = 1'b1;
    tick();

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
